uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 12_000_000, system clock in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, payload width; legal values 5..9.
REQ-004 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bit count; legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, at least 2.
REQ-007 SHALL have port: clock  input  1  system clock, all logic on its rising edge.
REQ-008 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port: wr_data  input  DATA_BITS  byte to queue.
REQ-010 SHALL have port: wr_en  input  1  one-clock write strobe.
REQ-011 SHALL have port: full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 SHALL have port: level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port: overflow  output  1  one-clock pulse when a write is dropped.
REQ-014 SHALL have port: busy  output  1  high whenever a frame is on the line.
REQ-015 SHALL have port: tx  output  1  serial line, idle high.

Function
REQ-016 SHALL define CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE, integer-truncated, with an elaboration error if the result is below 2.
REQ-017 SHALL emit frame order: start (0), DATA_BITS data bits LSB first, parity bit if PARITY != 0, STOP_BITS stop bits (1).
REQ-018 SHALL hold every bit on tx for exactly CLOCKS_PER_BIT clocks, with the divider restarted at frame start.
REQ-019 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when FIFO is non-empty; pop occurs on that same clock.
- START -> DATA after 1 bit time.
- DATA -> PARITY or STOP after DATA_BITS bit times.
- PARITY -> STOP after 1 bit time.
- STOP -> START if the FIFO is non-empty at the final stop-bit clock, popping on that clock; otherwise STOP -> IDLE.
REQ-020 SHALL drive the start bit on tx starting 1 clock after the first wr_en into an empty idle block; no idle gap between back-to-back frames.
REQ-021 SHALL compute parity over the latched payload: odd mode makes the total ones count odd; even mode makes it even.
REQ-022 SHALL latch the popped entry into a shift register; later FIFO writes never alter a frame in flight.
REQ-023 SHALL accept a write iff wr_en=1 and full=0, with full sampled before any same-cycle pop; a write while full is dropped and pulses overflow for 1 clock.
REQ-024 SHALL execute a simultaneous write and pop when not full; level is unchanged in that case.
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH, using an extra pointer bit to tell full from empty.
REQ-026 SHALL drive tx=1 and busy=0 in IDLE; busy=1 in START/DATA/PARITY/STOP.

Reset
REQ-027 SHALL on reset low immediately force tx=1, busy=0, full=0, level=0, overflow=0, FSM=IDLE, divider=0, and both pointers=0.
REQ-028 SHALL abort a frame in progress at reset, discard FIFO contents, and not resume the frame after reset release.
REQ-029 SHALL ignore wr_en while reset is low; the first accepted write is on the first rising clock after release.

Structure
REQ-030 SHALL place the FSM state enum, parity mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), and CLOCKS_PER_BIT helper function in shared package uart_pkg.
REQ-031 SHALL instantiate one sub-module, uart_sync_fifo (parameters WIDTH, DEPTH; outputs full/empty/level), for buffering; the serializer and divider stay in uart_tx_param.

Verification
(Bench uses CLOCK_FREQ=1_000_000 and BAUD_RATE=100_000, so CLOCKS_PER_BIT=10.)
REQ-032 SHALL verify 8N1: write 0x55 -> tx shows 0,1,0,1,0,1,0,1,0,1, each for 10 clocks; busy falls 100 clocks after the start bit.
REQ-033 SHALL verify parity: PARITY=2, write 0x07 -> parity bit 1; PARITY=1, write 0x07 -> parity bit 0; frame is 110 clocks.
REQ-034 SHALL verify back-to-back and STOP_BITS=2: write 0xA3 then 0x3C -> second start bit begins exactly 120 clocks after the first, with no idle gap.
REQ-035 SHALL verify overflow: 17 consecutive writes while the line is stalled in the first frame -> overflow pulses once, level peaks at 16, and exactly 17 frames minus 1 dropped = 16 frames plus the in-flight frame are correct.
REQ-036 SHALL verify reset mid-frame: assert reset at clock 45 of a frame -> tx=1 within the same cycle, level=0; after release, one new write yields one clean frame.
REQ-037 SHALL verify boundary: write and pop on the same clock with level=3 -> level remains 3; DATA_BITS=5 build transmits 0x1F as 5 ones.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter: FSM states,
// parity mode codes and the baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Integer-truncated clocks per serial bit.
    function automatic int clocks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; the extra pointer bit separates full from empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr, r_rptr;
    logic             w_wr, w_rd;

    // full is evaluated on current pointers, so a same-cycle pop never frees a slot early
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level   = r_wptr - r_rptr;
    assign o_rd_data = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: FIFO feeds a start/data/parity/stop serializer
// with a per-frame restarted baud divider.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 12_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          wr_en,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);
    localparam int CPB   = clocks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx_param: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_e            r_state, w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_overflow;
    logic                 w_tick, w_pop, w_empty, w_par_new;
    logic [DATA_BITS-1:0] w_rd_data;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (full),
        .o_empty   (w_empty),
        .o_level   (level)
    );

    assign w_tick    = (r_cnt == CNT_W'(CPB - 1));
    assign w_par_new = (PARITY == PAR_ODD) ? ~(^w_rd_data) : (^w_rd_data);
    assign busy      = (r_state != ST_IDLE);
    assign overflow  = r_overflow;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = ST_START;
                end
            end
            ST_START: if (w_tick) w_next = ST_DATA;
            ST_DATA: begin
                if (w_tick && r_bit == 4'(DATA_BITS - 1))
                    w_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: if (w_tick) w_next = ST_STOP;
            ST_STOP: begin
                // chain straight into the next start bit when more data is queued
                if (w_tick && r_bit == 4'(STOP_BITS - 1)) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = ST_START;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = r_shift[0];
            ST_PARITY: tx = r_par;
            default:   tx = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_en & full;
            if (r_state == ST_IDLE || w_tick) r_cnt <= '0;
            else                              r_cnt <= r_cnt + 1'b1;
            if (w_next != r_state)
                r_bit <= '0;
            else if (w_tick && (r_state == ST_DATA || r_state == ST_STOP))
                r_bit <= r_bit + 4'd1;
            if (w_pop) begin
                r_shift <= w_rd_data;
                r_par   <= w_par_new;
            end else if (r_state == ST_DATA && w_tick) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench: five builds of the transmitter checked against a
// frame-level reference model of the serial line.
module tb_uart_tx_param;
    localparam int CPB = 10;

    logic       clock = 1'b0;
    logic       reset;
    logic [8:0] wr_data;
    logic [4:0] wr_en_v;
    logic [4:0] tx_a, busy_a, full_a, ovf_a;
    logic [4:0] lvl_a [5];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_start_c = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (cyc > 20000) begin
            $display("FAIL watchdog: cycles=%0d limit=20000", cyc);
            $fatal(1, "watchdog");
        end
    end

    // 0: 8N1   1: 8E1   2: 8O1   3: 8E2   4: 5N1
    uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)) u_8n1 (
        .clock(clock), .reset(reset), .wr_data(wr_data[7:0]), .wr_en(wr_en_v[0]),
        .full(full_a[0]), .level(lvl_a[0]), .overflow(ovf_a[0]), .busy(busy_a[0]), .tx(tx_a[0]));
    uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(2)) u_8e1 (
        .clock(clock), .reset(reset), .wr_data(wr_data[7:0]), .wr_en(wr_en_v[1]),
        .full(full_a[1]), .level(lvl_a[1]), .overflow(ovf_a[1]), .busy(busy_a[1]), .tx(tx_a[1]));
    uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(1)) u_8o1 (
        .clock(clock), .reset(reset), .wr_data(wr_data[7:0]), .wr_en(wr_en_v[2]),
        .full(full_a[2]), .level(lvl_a[2]), .overflow(ovf_a[2]), .busy(busy_a[2]), .tx(tx_a[2]));
    uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(2), .STOP_BITS(2)) u_8e2 (
        .clock(clock), .reset(reset), .wr_data(wr_data[7:0]), .wr_en(wr_en_v[3]),
        .full(full_a[3]), .level(lvl_a[3]), .overflow(ovf_a[3]), .busy(busy_a[3]), .tx(tx_a[3]));
    uart_tx_param #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(5)) u_5n1 (
        .clock(clock), .reset(reset), .wr_data(wr_data[4:0]), .wr_en(wr_en_v[4]),
        .full(full_a[4]), .level(lvl_a[4]), .overflow(ovf_a[4]), .busy(busy_a[4]), .tx(tx_a[4]));

    function automatic int db_of(input int k);  return (k == 4) ? 5 : 8; endfunction
    function automatic int sb_of(input int k);  return (k == 3) ? 2 : 1; endfunction
    function automatic int par_of(input int k);
        return (k == 1 || k == 3) ? 2 : (k == 2) ? 1 : 0;
    endfunction
    function automatic int frame_len(input int k);
        return 1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k);
    endfunction

    // Line level of bit slot i of the frame carrying d.
    function automatic logic frame_bit(input int k, input logic [8:0] d, input int i);
        int ones = 0;
        for (int b = 0; b < db_of(k); b++) ones += int'(d[b]);
        if (i == 0) return 1'b0;
        if (i <= db_of(k)) return d[i-1];
        if (par_of(k) != 0 && i == db_of(k) + 1)
            return (par_of(k) == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int k, input logic [8:0] d);
        wr_data    = d;
        wr_en_v[k] = 1'b1;
        @(negedge clock);
        wr_en_v[k] = 1'b0;
    endtask

    // Waits for a start bit (unless already on it) then checks every clock of the frame.
    task automatic expect_frame(input int k, input logic [8:0] d, input bit started,
                                input int exp_wait, input bit idle_after, input string tag);
        int w = 0;
        int bad = 0;
        int n = frame_len(k) * CPB;
        if (!started) begin
            do begin
                @(negedge clock);
                w++;
            end while (tx_a[k] !== 1'b0 && w < 400);
            chk({tag, "_wait"}, w, exp_wait);
            if (tx_a[k] !== 1'b0) return;
        end
        last_start_c = cyc;
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clock);
            if (tx_a[k] !== frame_bit(k, d, j / CPB)) bad++;
            if (busy_a[k] !== 1'b1) bad++;
        end
        chk({tag, "_bits"}, bad, 0);
        if (idle_after) begin
            @(negedge clock);
            chk({tag, "_idle"}, {busy_a[k], tx_a[k]}, 2'b01);
        end
    endtask

    initial begin
        logic [8:0] d;
        logic [8:0] q [18];
        int t0, oc, lmax, fs, l1, bad;

        reset   = 1'b0;
        wr_en_v = '0;
        wr_data = 9'h012;
        wr_en_v[0] = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_level", lvl_a[0], 0);
        chk("rst_tx", tx_a[0], 1);
        chk("rst_busy", busy_a[0], 0);
        chk("rst_full", full_a[0], 0);
        chk("rst_ovf", ovf_a[0], 0);
        wr_en_v = '0;
        reset   = 1'b1;
        @(negedge clock);
        chk("rel_level", lvl_a[0], 0);

        send(0, 9'h055);
        chk("w55_level", lvl_a[0], 1);
        chk("w55_tx_idle", tx_a[0], 1);
        expect_frame(0, 9'h055, 0, 1, 1, "f55");
        repeat (3) begin
            d = 9'($urandom_range(0, 255));
            send(0, d);
            expect_frame(0, d, 0, 1, 1, "f8n1_rnd");
        end

        send(1, 9'h007);
        expect_frame(1, 9'h007, 0, 1, 1, "fe07");
        send(2, 9'h007);
        expect_frame(2, 9'h007, 0, 1, 1, "fo07");
        d = 9'($urandom_range(0, 255));
        send(1, d);
        expect_frame(1, d, 0, 1, 1, "fe_rnd");
        d = 9'($urandom_range(0, 255));
        send(2, d);
        expect_frame(2, d, 0, 1, 1, "fo_rnd");

        send(3, 9'h0A3);
        send(3, 9'h03C);
        chk("b2b_start", tx_a[3], 0);
        expect_frame(3, 9'h0A3, 1, 0, 0, "b2b1");
        t0 = last_start_c;
        expect_frame(3, 9'h03C, 0, 1, 1, "b2b2");
        chk("b2b_gap", last_start_c - t0, 120);

        for (int i = 0; i < 18; i++) q[i] = 9'($urandom_range(0, 255));
        oc = 0; lmax = 0; fs = 0; l1 = -1;
        send(0, q[0]);
        fork
            expect_frame(0, q[0], 0, 1, 0, "ovf_f0");
            begin
                for (int i = 1; i <= 17; i++) begin
                    wr_data    = q[i];
                    wr_en_v[0] = 1'b1;
                    @(negedge clock);
                    if (ovf_a[0] === 1'b1) oc++;
                    if (int'(lvl_a[0]) > lmax) lmax = int'(lvl_a[0]);
                    if (full_a[0] === 1'b1) fs = 1;
                    if (i == 1) l1 = int'(lvl_a[0]);
                end
                wr_en_v[0] = 1'b0;
                repeat (4) begin
                    @(negedge clock);
                    if (ovf_a[0] === 1'b1) oc++;
                end
            end
        join
        chk("wr_pop_lvl1", l1, 1);
        chk("ovf_pulses", oc, 1);
        chk("lvl_peak", lmax, 16);
        chk("full_seen", fs, 1);
        for (int i = 1; i <= 16; i++)
            expect_frame(0, q[i], 0, 1, (i == 16), "ovf_fifo");

        for (int i = 0; i < 5; i++) q[i] = 9'($urandom_range(0, 255));
        send(0, q[0]);
        @(negedge clock);
        chk("l3_start", tx_a[0], 0);
        for (int i = 1; i <= 3; i++) begin
            wr_data    = q[i];
            wr_en_v[0] = 1'b1;
            @(negedge clock);
        end
        wr_en_v[0] = 1'b0;
        repeat (96) @(negedge clock);
        chk("l3_pre", lvl_a[0], 3);
        wr_data    = q[4];
        wr_en_v[0] = 1'b1;
        @(negedge clock);
        wr_en_v[0] = 1'b0;
        chk("l3_post", lvl_a[0], 3);
        chk("l3_b2b", tx_a[0], 0);
        expect_frame(0, q[1], 1, 0, 0, "l3_f1");
        expect_frame(0, q[2], 0, 1, 0, "l3_f2");
        expect_frame(0, q[3], 0, 1, 0, "l3_f3");
        expect_frame(0, q[4], 0, 1, 1, "l3_f4");

        send(0, 9'h0F0);
        send(0, 9'h00F);
        chk("rm_start", tx_a[0], 0);
        repeat (45) @(negedge clock);
        chk("rm_lvl_pre", lvl_a[0], 1);
        reset = 1'b0;
        #1;
        chk("rm_tx", tx_a[0], 1);
        chk("rm_busy", busy_a[0], 0);
        chk("rm_lvl", lvl_a[0], 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clock);
            if (tx_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || lvl_a[0] !== 5'd0) bad++;
        end
        chk("rm_no_resume", bad, 0);
        d = 9'($urandom_range(0, 255));
        send(0, d);
        expect_frame(0, d, 0, 1, 1, "rm_new");

        send(4, 9'h01F);
        expect_frame(4, 9'h01F, 0, 1, 1, "f5_1f");
        d = 9'($urandom_range(0, 511));
        send(4, d);
        expect_frame(4, d, 0, 1, 1, "f5_rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
